// File: rtl/gpio_pkg.sv
// Shared types for the GPIO pixel collector: channel indices, push lane
// widths and the packed RGB pixel.
package gpio_pkg;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } channel_e;

  localparam int NUM_CH    = 3;
  localparam int LANES_VEC = 4;
  localparam int LANES_SCL = 1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/gpio_byte_fifo.sv
// Byte FIFO for one colour channel: accepts 1 or 4 bytes per push strobe
// (all-or-nothing), pops one byte at a time.
module gpio_byte_fifo
  import gpio_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CW    = PTR_W + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic [31:0]   i_data,
  input  logic          i_push,
  input  logic          i_vf,
  input  logic          i_pop,
  output logic [7:0]    o_head,
  output logic [CW-1:0] o_count,
  output logic          o_accept
);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_len;
  logic [CW-1:0]    w_space;
  logic             w_accept;
  logic             w_pop;

  // Space is judged on the registered count, so a same-cycle pop never
  // makes room for the push that arrives with it.
  assign w_len    = i_vf ? CW'(LANES_VEC) : CW'(LANES_SCL);
  assign w_space  = CW'(DEPTH) - r_count;
  assign w_accept = i_push && !i_clear && (w_space >= w_len);
  assign w_pop    = i_pop && !i_clear && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        for (int i = 0; i < LANES_VEC; i++) begin
          if (CW'(i) < w_len) begin
            r_mem[r_wr_ptr + PTR_W'(i)] <= i_data[8*i +: 8];
          end
        end
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_len);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + (w_accept ? w_len : '0) - CW'(w_pop);
    end
  end

  assign o_head   = r_mem[r_rd_ptr];
  assign o_count  = r_count;
  assign o_accept = w_accept;

endmodule

// File: rtl/gpio_pixel_collector.sv
// Collects GPIO byte writes into per-channel FIFOs and streams {R,G,B}
// pixels out once every channel holds a byte; tracks drops and pixel count.
module gpio_pixel_collector
  import gpio_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      gpio,
  input  logic             gpio_en_r,
  input  logic             gpio_en_g,
  input  logic             gpio_en_b,
  input  logic             gpio_vf,
  input  logic             clear,
  output logic [23:0]      pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             ovf_r,
  output logic             ovf_g,
  output logic             ovf_b,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] pix_cnt
);

  localparam int FCW = $clog2(DEPTH) + 1;

  logic              w_en     [NUM_CH];
  logic [7:0]        w_head   [NUM_CH];
  logic [FCW-1:0]    w_count  [NUM_CH];
  logic              w_accept [NUM_CH];
  logic [NUM_CH-1:0] w_drop;
  logic [1:0]        w_drop_num;
  logic [CNT_W:0]    w_drop_sum;
  logic              w_valid;
  logic              w_pop;
  pixel_t            w_pix;

  logic [NUM_CH-1:0] r_ovf;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [CNT_W-1:0]  r_pix_cnt;

  assign w_en[CH_R] = gpio_en_r;
  assign w_en[CH_G] = gpio_en_g;
  assign w_en[CH_B] = gpio_en_b;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gpio_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (clear),
      .i_data   (gpio),
      .i_push   (w_en[c]),
      .i_vf     (gpio_vf),
      .i_pop    (w_pop),
      .o_head   (w_head[c]),
      .o_count  (w_count[c]),
      .o_accept (w_accept[c])
    );
    assign w_drop[c] = w_en[c] && !clear && !w_accept[c];
  end

  assign w_valid = (w_count[CH_R] != '0) && (w_count[CH_G] != '0) &&
                   (w_count[CH_B] != '0);
  assign w_pop   = w_valid && pix_ready;

  assign w_pix.r = w_head[CH_R];
  assign w_pix.g = w_head[CH_G];
  assign w_pix.b = w_head[CH_B];

  // One extra MSB on the sum detects wrap so the drop counter saturates.
  assign w_drop_num = 2'(w_drop[0]) + 2'(w_drop[1]) + 2'(w_drop[2]);
  assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop_num);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf      <= '0;
      r_drop_cnt <= '0;
      r_pix_cnt  <= '0;
    end else if (clear) begin
      r_ovf      <= '0;
      r_drop_cnt <= '0;
      r_pix_cnt  <= '0;
    end else begin
      r_ovf      <= r_ovf | w_drop;
      r_drop_cnt <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
      if (w_pop) begin
        r_pix_cnt <= r_pix_cnt + CNT_W'(1);
      end
    end
  end

  assign pix_data  = w_pix;
  assign pix_valid = w_valid;
  assign ovf_r     = r_ovf[CH_R];
  assign ovf_g     = r_ovf[CH_G];
  assign ovf_b     = r_ovf[CH_B];
  assign drop_cnt  = r_drop_cnt;
  assign pix_cnt   = r_pix_cnt;

endmodule

// File: tb/tb_gpio_pixel_collector.sv
// Scoreboard bench: per-channel byte queues model the FIFOs; a monitor on the
// falling edge compares every presented pixel and the debug counters.
module tb_gpio_pixel_collector;

  localparam int DEPTH = 16;
  localparam int CNT_W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] gpio = '0;
  logic        gpio_en_r = 1'b0;
  logic        gpio_en_g = 1'b0;
  logic        gpio_en_b = 1'b0;
  logic        gpio_vf = 1'b0;
  logic        clear = 1'b0;
  logic        pix_ready = 1'b0;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        ovf_r, ovf_g, ovf_b;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] pix_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]  qR[$];
  logic [7:0]  qG[$];
  logic [7:0]  qB[$];
  logic        popPending = 1'b0;
  logic        expValid;
  int unsigned mPix = 0;
  int unsigned mDrop = 0;
  logic [2:0]  mOvf = '0;

  always #5 clk = ~clk;

  gpio_pixel_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gpio      (gpio),
    .gpio_en_r (gpio_en_r),
    .gpio_en_g (gpio_en_g),
    .gpio_en_b (gpio_en_b),
    .gpio_vf   (gpio_vf),
    .clear     (clear),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .ovf_r     (ovf_r),
    .ovf_g     (ovf_g),
    .ovf_b     (ovf_b),
    .drop_cnt  (drop_cnt),
    .pix_cnt   (pix_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelChannel(input int ch, input logic en);
    int n;
    int occ;
    if (!en) return;
    n = gpio_vf ? 4 : 1;
    case (ch)
      0:       occ = qR.size();
      1:       occ = qG.size();
      default: occ = qB.size();
    endcase
    occ += popPending ? 1 : 0;
    if (DEPTH - occ >= n) begin
      for (int k = 0; k < n; k++) begin
        case (ch)
          0:       qR.push_back(gpio[8*k +: 8]);
          1:       qG.push_back(gpio[8*k +: 8]);
          default: qB.push_back(gpio[8*k +: 8]);
        endcase
      end
    end else begin
      mOvf[ch] = 1'b1;
      if (mDrop != 32'hFFFF_FFFF) mDrop++;
    end
  endtask

  // Rising edge updates the reference model; falling edge is the monitor.
  always @(posedge clk or negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qR.delete(); qG.delete(); qB.delete();
      mPix = 0; mDrop = 0; mOvf = '0; popPending = 1'b0;
    end else if (clk) begin
      if (clear) begin
        qR.delete(); qG.delete(); qB.delete();
        mPix = 0; mDrop = 0; mOvf = '0;
      end else begin
        if (popPending) mPix++;
        modelChannel(0, gpio_en_r);
        modelChannel(1, gpio_en_g);
        modelChannel(2, gpio_en_b);
      end
      popPending = 1'b0;
    end else begin
      expValid = (qR.size() != 0) && (qG.size() != 0) && (qB.size() != 0);
      checkOutput("pix_valid", 32'(pix_valid), 32'(expValid));
      if (expValid && pix_valid)
        checkOutput("pix_data", 32'(pix_data), {8'h00, qR[0], qG[0], qB[0]});
      checkOutput("pix_cnt", pix_cnt, mPix);
      checkOutput("drop_cnt", drop_cnt, mDrop);
      checkOutput("ovf", {29'd0, ovf_r, ovf_g, ovf_b}, {29'd0, mOvf[0], mOvf[1], mOvf[2]});
      if (expValid && pix_ready) begin
        void'(qR.pop_front()); void'(qG.pop_front()); void'(qB.pop_front());
        popPending = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input logic er, input logic eg, input logic eb,
                               input logic v, input logic [31:0] d,
                               input logic rdy, input logic clr);
    gpio_en_r = er; gpio_en_g = eg; gpio_en_b = eb;
    gpio_vf = v; gpio = d; pix_ready = rdy; clear = clr;
    @(posedge clk);
    #1;
    gpio_en_r = 1'b0; gpio_en_g = 1'b0; gpio_en_b = 1'b0;
    gpio_vf = 1'b0; clear = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, 32'(pix_valid), 32'd0);
    checkOutput({tag, "_data"}, 32'(pix_data), 32'd0);
    checkOutput({tag, "_drop"}, drop_cnt, 32'd0);
    checkOutput({tag, "_pixcnt"}, pix_cnt, 32'd0);
    checkOutput({tag, "_ovf"}, {29'd0, ovf_r, ovf_g, ovf_b}, 32'd0);
  endtask

  initial begin
    #12;
    checkResetState("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(1, 0, 0, 0, 32'h11, 1, 0);
    applyStimulus(0, 1, 0, 0, 32'h22, 1, 0);
    applyStimulus(0, 0, 1, 0, 32'h33, 1, 0);
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
    checkOutput("scalar_pix_cnt", pix_cnt, 32'd1);
    checkOutput("scalar_empty", 32'(pix_valid), 32'd0);

    applyStimulus(1, 0, 0, 1, 32'h4433_2211, 1, 0);
    applyStimulus(0, 1, 0, 1, 32'h4433_2211, 1, 0);
    applyStimulus(0, 0, 1, 1, 32'h4433_2211, 1, 0);
    repeat (4) applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
    checkOutput("vector_pix_cnt", pix_cnt, 32'd5);

    applyStimulus(1, 1, 1, 0, 32'hA5, 0, 0);
    applyStimulus(1, 1, 1, 0, 32'h5A, 0, 0);
    repeat (5) applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
    checkOutput("bp_valid", 32'(pix_valid), 32'd1);
    checkOutput("bp_data", 32'(pix_data), 32'h00A5_A5A5);
    repeat (2) applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
    checkOutput("bp_pix_cnt", pix_cnt, 32'd7);

    applyStimulus(0, 0, 0, 0, 32'h0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1, 32'hC0C1C2C3 + 32'(i), 0, 0);
    applyStimulus(1, 0, 0, 0, 32'hEE, 0, 0);
    checkOutput("ovf_r", 32'(ovf_r), 32'd1);
    checkOutput("ovf_gb", {30'd0, ovf_g, ovf_b}, 32'd0);
    checkOutput("ovf_drop", drop_cnt, 32'd1);

    applyStimulus(0, 1, 0, 0, 32'h66, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'h67, 0, 0);
    checkOutput("edge_head", 32'(pix_data), 32'h00C3_6667);
    applyStimulus(1, 0, 0, 0, 32'h77, 1, 0);
    checkOutput("edge_drop", drop_cnt, 32'd2);
    checkOutput("edge_pix_cnt", pix_cnt, 32'd1);

    applyStimulus(1, 1, 1, 0, 32'h99, 1, 1);
    checkOutput("clr_drop", drop_cnt, 32'd0);
    checkOutput("clr_valid", 32'(pix_valid), 32'd0);
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
    checkOutput("clr_nopush", 32'(pix_valid), 32'd0);

    applyStimulus(1, 1, 0, 0, 32'h12, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("async");
    @(posedge clk); #3;
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 32'h01, 1, 0);
    applyStimulus(0, 1, 0, 0, 32'h02, 1, 0);
    applyStimulus(0, 0, 1, 0, 32'h03, 1, 0);
    checkOutput("post_rst_data", 32'(pix_data), 32'h0001_0203);
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
    checkOutput("post_rst_cnt", pix_cnt, 32'd1);

    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    $urandom, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 99) == 0);
    end
    repeat (20) applyStimulus(0, 0, 0, 0, 32'h0, 1, 0);
    checkOutput("drained", 32'(pix_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
